// File: rtl/demux_nbit_x4_dispatch_if.sv
// Handshake bundle between a tagged-word producer, the dispatch FIFO and the
// four per-channel consumers behind demux_nbit_x4.
interface demux_nbit_x4_dispatch_if #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                 in_valid;
  logic                 in_ready;
  logic [BUS_WIDTH-1:0] in_data;
  logic [1:0]           in_dest;
  logic [1:0]           sel;
  logic [BUS_WIDTH-1:0] y;
  logic [3:0]           out_valid;
  logic [3:0]           out_ready;
  logic [CNT_W-1:0]     count;

  modport master (
    output in_valid, in_data, in_dest, out_ready,
    input  in_ready, sel, y, out_valid, count
  );

  modport slave (
    input  in_valid, in_data, in_dest, out_ready,
    output in_ready, sel, y, out_valid, count
  );
endinterface

// File: rtl/demux_nbit_x4_dispatch.sv
// Tagged-word FIFO feeding demux_nbit_x4: presents the head entry as sel/y and
// pops it only when the addressed channel is ready (strict order, HOL blocking).
module demux_nbit_x4_dispatch #(
  parameter int BUS_WIDTH = 8,
  parameter int DEPTH     = 4
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      flush,
  demux_nbit_x4_dispatch_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = BUS_WIDTH + 2;

  logic [ENT_W-1:0]     mem [DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     cnt;

  logic                 not_empty;
  logic                 push;
  logic                 pop;
  logic [ENT_W-1:0]     head;
  logic [1:0]           head_dest;
  logic [BUS_WIDTH-1:0] head_data;

  assign not_empty = (cnt != '0);
  assign head      = mem[rd_ptr];
  assign head_dest = head[ENT_W-1 -: 2];
  assign head_data = head[BUS_WIDTH-1:0];

  // in_ready depends on registered occupancy only, so a full FIFO stays
  // closed during the cycle its head is popped.
  assign bus.in_ready = (cnt != CNT_W'(DEPTH));
  assign bus.count    = cnt;

  assign push = bus.in_valid && bus.in_ready;
  assign pop  = not_empty && bus.out_ready[head_dest];

  always_comb begin
    bus.sel       = 2'd0;
    bus.y         = '0;
    bus.out_valid = 4'b0000;
    if (not_empty) begin
      bus.sel       = head_dest;
      bus.y         = head_data;
      bus.out_valid = 4'b0001 << head_dest;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   cnt <= cnt + CNT_W'(1);
        2'b01:   cnt <= cnt - CNT_W'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not reset; an entry is only observable once cnt covers it.
  always_ff @(posedge clk) begin
    if (reset_n && !flush && push) begin
      mem[wr_ptr] <= {bus.in_dest, bus.in_data};
    end
  end
endmodule

// File: tb/tb_demux_nbit_x4_dispatch.sv
// Directed bench for demux_nbit_x4_dispatch with a queue-based reference model.
module tb_demux_nbit_x4_dispatch;
  localparam int BW    = 8;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [1:0]    dest;
    logic [BW-1:0] data;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n;
  logic flush;
  int   n_cmp  = 0;
  int   n_fail = 0;
  ent_t q[$];

  always #5 clk = ~clk;

  demux_nbit_x4_dispatch_if #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) bus ();

  demux_nbit_x4_dispatch #(.BUS_WIDTH(BW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, check outputs against the model, then advance.
  task automatic step(input logic rn, input logic fl, input logic iv,
                      input logic [BW-1:0] d, input logic [1:0] ds,
                      input logic [3:0] ordy);
    logic do_push;
    logic do_pop;
    reset_n       = rn;
    flush         = fl;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.in_dest   = ds;
    bus.out_ready = ordy;
    #1;
    chk("count", 32'(bus.count), 32'(q.size()));
    chk("in_ready", 32'(bus.in_ready), 32'(q.size() != DEPTH));
    if (q.size() > 0) begin
      chk("sel", 32'(bus.sel), 32'(q[0].dest));
      chk("y", 32'(bus.y), 32'(q[0].data));
      chk("out_valid", 32'(bus.out_valid), 32'(4'b0001 << q[0].dest));
    end else begin
      chk("sel_empty", 32'(bus.sel), 32'd0);
      chk("y_empty", 32'(bus.y), 32'd0);
      chk("out_valid_empty", 32'(bus.out_valid), 32'd0);
    end
    if (!rn || fl) begin
      q.delete();
    end else begin
      do_pop  = (q.size() > 0) && ordy[q[0].dest];
      do_push = iv && (q.size() != DEPTH);
      if (do_pop) begin
        chk("pop_y", 32'(bus.y), 32'(q[0].data));
        chk("pop_sel", 32'(bus.sel), 32'(q[0].dest));
        void'(q.pop_front());
      end
      if (do_push) q.push_back('{dest: ds, data: d});
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n       = 1'b0;
    flush         = 1'b0;
    bus.in_valid  = 1'b1;
    bus.in_data   = 8'hAA;
    bus.in_dest   = 2'd2;
    bus.out_ready = 4'b0000;
    @(posedge clk);
    #1;

    // Reset held with a pending word, then one idle cycle after release.
    step(1'b0, 1'b0, 1'b1, 8'hAA, 2'd2, 4'b0000);
    step(1'b0, 1'b0, 1'b1, 8'hAA, 2'd2, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);

    // Single routed word; wrong-channel ready must not pop it.
    step(1'b1, 1'b0, 1'b1, 8'h5A, 2'd2, 4'b0000);
    chk("single_sel", 32'(bus.sel), 32'd2);
    chk("single_y", 32'(bus.y), 32'h5A);
    chk("single_ov", 32'(bus.out_valid), 32'b0100);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1011);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0100);
    chk("single_drained", 32'(bus.count), 32'd0);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);

    // Fill to full, try a 5th word, then pop while full with in_valid high.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b1, 8'(8'h10 + i), 2'(i), 4'b0000);
    chk("full_count", 32'(bus.count), 32'd4);
    step(1'b1, 1'b0, 1'b1, 8'hEE, 2'd1, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 8'h14, 2'd1, 4'b0001);
    chk("after_full_head", 32'(bus.y), 32'h11);
    chk("after_full_ready", 32'(bus.in_ready), 32'd1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);

    // Streaming through the pointer wrap with simultaneous push and pop.
    for (int i = 0; i < 12; i++) step(1'b1, 1'b0, 1'b1, 8'(i), 2'(i % 4), 4'b1111);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);

    // Head-of-line blocking: dest 0 ready cannot bypass a dest 3 head.
    step(1'b1, 1'b0, 1'b1, 8'hC3, 2'd3, 4'b0001);
    step(1'b1, 1'b0, 1'b1, 8'hC0, 2'd0, 4'b0001);
    chk("hol_sel", 32'(bus.sel), 32'd3);
    chk("hol_ov", 32'(bus.out_valid), 32'b1000);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0001);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1001);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1001);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0000);

    // Flush at count 3 alongside a push and a matching pop.
    step(1'b1, 1'b0, 1'b1, 8'h21, 2'd1, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 8'h22, 2'd2, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 8'h23, 2'd3, 4'b0000);
    step(1'b1, 1'b1, 1'b1, 8'h99, 2'd0, 4'b0010);
    chk("flush_count", 32'(bus.count), 32'd0);
    chk("flush_ov", 32'(bus.out_valid), 32'd0);
    step(1'b1, 1'b0, 1'b1, 8'h77, 2'd1, 4'b0000);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b0010);

    // Reset mid-operation drops buffered words.
    step(1'b1, 1'b0, 1'b1, 8'h31, 2'd0, 4'b0000);
    step(1'b1, 1'b0, 1'b1, 8'h32, 2'd1, 4'b0000);
    step(1'b0, 1'b1, 1'b1, 8'h33, 2'd2, 4'b1111);
    step(1'b1, 1'b0, 1'b0, 8'h00, 2'd0, 4'b1111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_nbit_x4_dispatch.md
Name: demux_nbit_x4_dispatch

Overview:
- Upstream feeder for demux_nbit_x4.
- Accepts a tagged data stream (data plus 2-bit destination), buffers it in a small FIFO, and presents the head entry as sel/y to the demux.
- Raises a one-hot per-channel valid and pops the entry only when the addressed channel asserts ready.
- Decouples the producer from per-channel backpressure on outputs a/b/c/d.

Parameters:
- BUS_WIDTH, 8: width of data path; matches demux_nbit_x4 BUS_WIDTH.
- DEPTH, 4: FIFO entries; power of 2, minimum 2.

Ports:
- clk, input, 1: single clock, rising edge.
- reset_n, input, 1: synchronous, active-low reset.
- flush, input, 1: synchronous clear of FIFO contents.
- in_valid, input, 1: producer has a word.
- in_ready, output, 1: FIFO can accept a word.
- in_data, input, BUS_WIDTH: word to route.
- in_dest, input, 2: destination channel; 0=a, 1=b, 2=c, 3=d.
- sel, output, 2: to demux sel; destination of head entry.
- y, output, BUS_WIDTH: to demux y; data of head entry.
- out_valid, output, 4: one-hot; bit[sel] set when head entry present.
- out_ready, input, 4: per-channel consumer ready.
- count, output, $clog2(DEPTH)+1: current occupancy.

Behaviour:
- Reset: while reset_n=0 at a rising edge, all of the following are cleared:
  - wr_ptr, rd_ptr and count = 0.
  - Outputs: in_ready=1, out_valid=0, sel=0, y=0.
  - Storage contents are don't-care.
- Push:
  - in_ready = (count != DEPTH); it is registered-state derived and has no combinational path from out_ready.
  - A push occurs when in_valid && in_ready.
  - {in_dest, in_data} is written at wr_ptr; wr_ptr increments modulo DEPTH.
- Head presentation (combinational from registered state only):
  - count==0: sel=0, y=0, out_valid=4'b0000.
  - count>0: sel=head dest, y=head data, out_valid = 1<<head dest.
- Pop:
  - A pop occurs when count>0 && out_ready[sel].
  - rd_ptr increments modulo DEPTH.
  - Ready on channels other than sel is ignored.
- Latency: a word pushed into an empty FIFO at edge N appears on sel/y/out_valid after edge N; it can be popped at edge N+1. There is no same-cycle bypass.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Legal at any non-full occupancy, including count==1.
- Full (count==DEPTH):
  - in_ready=0, even if the head is popped in the same cycle.
  - in_ready returns to 1 the cycle after the pop.
- Empty: out_valid=0; out_ready is ignored and count never underflows.
- Pointer wrap: pointers are $clog2(DEPTH) bits and wrap naturally; FIFO order is preserved across the wrap.
- Ordering:
  - Strict FIFO order is kept across all channels.
  - A head blocked by its channel's out_ready=0 blocks every later entry (head-of-line blocking is intended).
- flush:
  - When flush=1 (and reset_n=1), pointers and count clear at the edge.
  - Any push or pop in that cycle is discarded.
  - Next cycle: out_valid=0, in_ready=1.
- Reset mid-operation: takes effect at the next edge regardless of in_valid/out_ready/flush; buffered words are lost.
- Priority: reset_n=0 > flush > push/pop.

Test Plan:
- Reset:
  - Stimulus: hold reset_n=0 for 2 cycles with in_valid=1, in_data=8'hAA, in_dest=2.
  - Response: count=0, out_valid=0, sel=0, y=0, in_ready=1 throughout and one cycle after release.
- Single routed word:
  - Stimulus: push in_data=8'h5A, in_dest=2 with out_ready=4'b0000.
  - Response: next cycle sel=2, y=8'h5A, out_valid=4'b0100, count=1.
  - Follow-up: assert out_ready=4'b1011; the word is not popped.
  - Follow-up: assert out_ready=4'b0100; the word is popped and count=0 the next cycle.
- Fill and full:
  - Stimulus: push 4 words (8'h10,8'h11,8'h12,8'h13; dests 0,1,2,3) with out_ready=0.
  - Response: count=4, in_ready=0, and a 5th in_valid is not accepted.
  - Follow-up: pop with out_ready=4'b0001; in_ready=1 the next cycle; the head becomes 8'h11 with sel=1.
- Streaming wrap and order:
  - Stimulus: push 8'h00..8'h0B with in_dest=i%4; hold out_ready=4'b1111 with pushes on every cycle.
  - Response: count stays at 1, and y sequence equals 8'h00..8'h0B in order with sel=i%4.
  - Pointers wrap 3 times.
- Head-of-line blocking:
  - Stimulus: queue dest 3 (8'hC3) then dest 0 (8'hC0), with out_ready=4'b0001.
  - Response: no pop; sel=3, out_valid=4'b1000.
  - Follow-up: set out_ready=4'b1001; 8'hC3 pops, then 8'hC0 pops.
- Flush and simultaneous events:
  - Stimulus: with count=3, assert flush together with in_valid=1 and a matching out_ready.
  - Response: next cycle count=0, out_valid=0, in_ready=1; the pushed word is absent.
